imem_loader: RTL and testbench

- Writer side of the 32-entry, 20-bit instruction memory that the fetch stage reads.
- Accepts a program as a stream of 20-bit instruction words over a valid/ready handshake and stores them sequentially from address 0.
- Exposes a combinational read port indexed by the fetch index.
- Holds the core off (busy) while a load is in progress.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/imem_array.sv | 31 +++
 rtl/imem_loader.sv | 99 +++++++++
 tb/tb_imem_loader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word geometry and the instruction-memory
// loader state encoding.
package cpu_pkg;

    localparam int WORD_W = 20;
    localparam int PTR_W  = 5;
    localparam int DEPTH  = 32;

    // Instruction field offsets: opcode[4:0], addrA[9:5], addrB[14:10], addrW[19:15].
    localparam int OP_LSB = 0;
    localparam int A_LSB  = 5;
    localparam int B_LSB  = 10;
    localparam int W_LSB  = 15;

    typedef logic [WORD_W-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } loaderState_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x WORD_W instruction storage: one synchronous write port, a synchronous
// clear of every word, and an asynchronous read port.
module imem_array
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              clearAll,
    input  logic              wrEn,
    input  logic [PTR_W-1:0]  wrAddr,
    input  logic [WORD_W-1:0] wrData,
    input  logic [PTR_W-1:0]  rdAddr,
    output logic [WORD_W-1:0] rdData
);

    instr_t mem [DEPTH];

    // NOTE: the storage is reset on purpose: unwritten locations must read 0
    // after every load, so the clear is part of the function, not just init.
    always_ff @(posedge clk) begin
        if (clearAll) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: streams a program in over valid/ready,
// stores it from address 0, and holds the core off while the load runs.
module imem_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic [WORD_W-1:0] fetch_idx,
    output logic [WORD_W-1:0] fetch_instr,
    output logic [PTR_W:0]    load_count,
    output logic              busy,
    output logic              done,
    output logic              trunc_err
);

    loaderState_t     state;
    logic [PTR_W-1:0] wrPtr;
    logic             transfer;
    logic             beginLoad;
    logic             lastSlot;
    logic             clearAll;
    logic [WORD_W-1:0] rdData;
    logic             unusedFetchHi;

    assign transfer  = in_valid & in_ready;
    assign beginLoad = start && (state == IDLE || state == DONE);
    assign lastSlot  = (wrPtr == PTR_W'(DEPTH - 1));
    assign clearAll  = rst || beginLoad;

    // Indices wrap modulo DEPTH; the upper index bits carry no meaning here.
    assign unusedFetchHi = ^fetch_idx[WORD_W-1:PTR_W];

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wrPtr      <= '0;
            load_count <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trunc_err  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        wrPtr      <= '0;
                        load_count <= '0;
                        trunc_err  <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (transfer) begin
                        wrPtr      <= wrPtr + 1'b1;
                        load_count <= load_count + 1'b1;
                        // The final slot ends the load even without in_last.
                        if (in_last || lastSlot) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            trunc_err <= lastSlot && !in_last;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    imem_array u_imem_array (
        .clk      (clk),
        .clearAll (clearAll),
        .wrEn     (transfer),
        .wrAddr   (wrPtr),
        .wrData   (in_data),
        .rdAddr   (fetch_idx[PTR_W-1:0]),
        .rdData   (rdData)
    );

    // The fetch stage sees opcode 0 while the program is being replaced.
    assign fetch_instr = busy ? '0 : rdData;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, short/gapped/full loads, reload,
// fetch gating and wrap, all against hand-computed expectations.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        in_last;
    logic [19:0] fetch_idx;
    logic [19:0] fetch_instr;
    logic [5:0]  load_count;
    logic        busy;
    logic        done;
    logic        trunc_err;

    int vecCount  = 0;
    int missCount = 0;

    imem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .fetch_idx   (fetch_idx),
        .fetch_instr (fetch_instr),
        .load_count  (load_count),
        .busy        (busy),
        .done        (done),
        .trunc_err   (trunc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sendWord(input logic [19:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic readCheck(input logic [19:0] idx, input logic [19:0] exp);
        fetch_idx = idx;
        #1;
        check($sformatf("fetch[0x%0h]", idx), fetch_instr, exp);
    endtask

    logic [19:0] gapData  [5] = '{20'h11111, 20'h22222, 20'h33333, 20'h44444, 20'h55555};
    logic        gapValid [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; fetch_idx = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", load_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 0);
        check("rst_trunc", trunc_err, 0);

        // A word offered before start must be refused.
        in_valid = 1'b1; in_data = 20'hABCDE;
        tick();
        in_valid = 1'b0;
        check("idle_ready", in_ready, 0);
        check("idle_count", load_count, 0);

        // Short program with a mid-load start and gated fetch.
        pulseStart();
        check("load_busy", busy, 1);
        check("load_ready", in_ready, 1);
        sendWord(20'h00421, 1'b0);
        readCheck(20'h0, 20'h0);
        pulseStart();
        check("ign_start_count", load_count, 1);
        check("ign_start_busy", busy, 1);
        sendWord(20'h8C862, 1'b0);
        sendWord(20'hFFFFF, 1'b1);
        check("short_done", done, 1);
        check("short_busy", busy, 0);
        check("short_ready", in_ready, 0);
        check("short_count", load_count, 3);
        check("short_trunc", trunc_err, 0);
        readCheck(20'h0, 20'h00421);
        readCheck(20'h1, 20'h8C862);
        readCheck(20'h2, 20'hFFFFF);
        readCheck(20'h3, 20'h0);

        // Gaps in in_valid: only valid cycles write.
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            in_valid = gapValid[i];
            in_data  = gapData[i];
            in_last  = (i == 4);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("gap_count", load_count, 3);
        check("gap_done", done, 1);
        readCheck(20'h0, 20'h11111);
        readCheck(20'h1, 20'h44444);
        readCheck(20'h2, 20'h55555);
        readCheck(20'h3, 20'h0);

        // Reset in the middle of a load discards everything.
        pulseStart();
        sendWord(20'h0AAAA, 1'b0);
        sendWord(20'h0BBBB, 1'b0);
        sendWord(20'h0CCCC, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("midrst_count", load_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", in_ready, 0);
        for (int i = 0; i < 32; i++) readCheck(20'(i), 20'h0);

        // Full 32-word load without in_last.
        pulseStart();
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check("full_pre_done", done, 0);
            sendWord(20'(i * 32'h1111), 1'b0);
        end
        check("full_done", done, 1);
        check("full_count", load_count, 32);
        check("full_trunc", trunc_err, 1);
        check("full_ready", in_ready, 0);
        readCheck(20'h00025, 20'h05555);
        readCheck(20'h0001F, 20'h2110F);
        readCheck(20'hFFFE0, 20'h00000);

        // Reload one word over a full memory.
        pulseStart();
        check("reload_trunc_clr", trunc_err, 0);
        check("reload_count_clr", load_count, 0);
        sendWord(20'h12345, 1'b1);
        check("reload_count", load_count, 1);
        check("reload_trunc", trunc_err, 0);
        check("reload_done", done, 1);
        for (int i = 0; i < 32; i++) readCheck(20'(i), (i == 0) ? 20'h12345 : 20'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
